sram_demux_1x2: RTL and testbench

- Routes one CPU-side SRAM-style data request to one of two slaves: data RAM (slave 0) or confreg (slave 1).
- Slave choice is an address decode against a window.
- On the return path, read data from the selected slave is steered back to the CPU using a per-request select tag. The tag is pipelined to match the slave read latency.
- Sits between the CPU data port and the SoC memory/peripheral slaves. It is the one-to-many counterpart of the datapath select muxes.

---
 rtl/sram_demux_1x2_if.sv | 39 +++
 rtl/sram_demux_1x2.sv | 130 +++++++++++++
 tb/tb_sram_demux_1x2.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_demux_1x2_if.sv
// sram_demux_1x2_if: bus bundle for the 1-to-2 SRAM request demux.
// Carries the CPU-side request/return signals and both slave-side ports.
// The demux uses the "slave" modport; the surrounding environment (CPU plus
// the two slave memories) uses the "master" modport.
interface sram_demux_1x2_if;
    // CPU side
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    // Slave 0: data RAM
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    // Slave 1: confreg
    logic        conf_en;
    logic [3:0]  conf_wen;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;

    modport master (
        output cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata, conf_rdata,
        input  cpu_rdata, cpu_rvalid,
        input  ram_en, ram_wen, ram_addr, ram_wdata,
        input  conf_en, conf_wen, conf_addr, conf_wdata
    );

    modport slave (
        input  cpu_en, cpu_wen, cpu_addr, cpu_wdata, ram_rdata, conf_rdata,
        output cpu_rdata, cpu_rvalid,
        output ram_en, ram_wen, ram_addr, ram_wdata,
        output conf_en, conf_wen, conf_addr, conf_wdata
    );
endinterface

// File: rtl/sram_demux_1x2.sv
// sram_demux_1x2: routes a CPU SRAM-style data request to the data RAM
// (slave 0) or the confreg block (slave 1) by decoding the address against
// the confreg window, and steers the returning read data back to the CPU
// using a select tag delayed by the shared slave read latency RD_LAT (1..4).
// Read data appears on cpu_rdata/cpu_rvalid RD_LAT+1 cycles after issue.
//
// Optional build macro SRAM_DEMUX_STAT_EN adds saturating 16-bit per-slave
// access counters (stat_ram_cnt / stat_conf_cnt).
module sram_demux_1x2 #(
    parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
    parameter logic [31:0] CONF_MASK = 32'hFFFF_0000,
    parameter int          RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef SRAM_DEMUX_STAT_EN
    output logic [15:0]          stat_ram_cnt,
    output logic [15:0]          stat_conf_cnt,
`endif
    sram_demux_1x2_if.slave      bus
);

    localparam int LAST = RD_LAT - 1;

    logic              hit;
    logic [RD_LAT-1:0] tag_v_q;
    logic [RD_LAT-1:0] tag_v_d;
    logic [RD_LAT-1:0] tag_sel_q;
    logic [RD_LAT-1:0] tag_sel_d;
    logic [31:0]       cpu_rdata_q;
    logic [31:0]       cpu_rdata_d;
    logic              cpu_rvalid_q;
    logic              cpu_rvalid_d;

    assign hit = ((bus.cpu_addr & CONF_MASK) == CONF_BASE);

    // Request path: enable/byte-enables go only to the decoded slave; both
    // are forced inactive while reset is held, whatever the CPU drives.
    always_comb begin
        bus.ram_en   = 1'b0;
        bus.conf_en  = 1'b0;
        bus.ram_wen  = 4'h0;
        bus.conf_wen = 4'h0;
        if (!reset) begin
            bus.ram_en   = bus.cpu_en & ~hit;
            bus.conf_en  = bus.cpu_en & hit;
            bus.ram_wen  = hit ? 4'h0 : bus.cpu_wen;
            bus.conf_wen = hit ? bus.cpu_wen : 4'h0;
        end
    end

    // Address and write data are shared wires to both slaves.
    assign bus.ram_addr   = bus.cpu_addr;
    assign bus.conf_addr  = bus.cpu_addr;
    assign bus.ram_wdata  = bus.cpu_wdata;
    assign bus.conf_wdata = bus.cpu_wdata;

    // Tag stage 0 captures every cycle: a valid bit for reads only (writes
    // still occupy a slot but never return data) and the slave select.
    assign tag_v_d[0]   = bus.cpu_en & (bus.cpu_wen == 4'h0);
    assign tag_sel_d[0] = hit;

    for (genvar g = 1; g < RD_LAT; g++) begin : g_tag_shift
        assign tag_v_d[g]   = tag_v_q[g-1];
        assign tag_sel_d[g] = tag_sel_q[g-1];
    end

    // Return path: when the oldest tag is valid the slave is presenting its
    // data this cycle; pick it by the tag select and ignore the other slave.
    always_comb begin
        cpu_rvalid_d = tag_v_q[LAST];
        cpu_rdata_d  = cpu_rdata_q;
        if (tag_v_q[LAST]) begin
            cpu_rdata_d = tag_sel_q[LAST] ? bus.conf_rdata : bus.ram_rdata;
        end
    end

    // Tag pipeline advance; reset discards every outstanding read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v_q   <= '0;
            tag_sel_q <= '0;
        end else begin
            tag_v_q   <= tag_v_d;
            tag_sel_q <= tag_sel_d;
        end
    end

    // Registered CPU return data and its one-cycle valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q  <= 32'h0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;

`ifdef SRAM_DEMUX_STAT_EN
    logic [15:0] stat_ram_q;
    logic [15:0] stat_conf_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Per-slave access counters: count every enabled cycle, stick at max.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ram_q  <= 16'h0;
            stat_conf_q <= 16'h0;
        end else begin
            if (bus.ram_en) begin
                stat_ram_q <= sat_inc16(stat_ram_q);
            end
            if (bus.conf_en) begin
                stat_conf_q <= sat_inc16(stat_conf_q);
            end
        end
    end

    assign stat_ram_cnt  = stat_ram_q;
    assign stat_conf_cnt = stat_conf_q;
`endif

endmodule

// File: tb/tb_sram_demux_1x2.sv
// tb_sram_demux_1x2: self-checking bench for sram_demux_1x2.
// Three instances (RD_LAT = 1, 2, 3) share the CPU stimulus; each has its
// own pair of slave models that return address-derived data after the
// instance's latency and drive 32'hDEAD_BEEF when not returning data.
// Expected read results go into a per-instance queue when a read is driven
// and are checked against cpu_rvalid/cpu_rdata on every cycle.
module tb_sram_demux_1x2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [9:0]  exp_ctl;   // {ram_en, ram_wen, conf_en, conf_wen}
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];

    sram_demux_1x2_if if0 ();
    sram_demux_1x2_if if1 ();
    sram_demux_1x2_if if2 ();

`ifdef SRAM_DEMUX_STAT_EN
    logic [15:0] st_ram0, st_conf0, st_ram1, st_conf1, st_ram2, st_conf2;
`endif

    sram_demux_1x2 #(.RD_LAT(1)) u0 (
        .clk(clk), .reset(rst),
`ifdef SRAM_DEMUX_STAT_EN
        .stat_ram_cnt(st_ram0), .stat_conf_cnt(st_conf0),
`endif
        .bus(if0)
    );
    sram_demux_1x2 #(.RD_LAT(2)) u1 (
        .clk(clk), .reset(rst),
`ifdef SRAM_DEMUX_STAT_EN
        .stat_ram_cnt(st_ram1), .stat_conf_cnt(st_conf1),
`endif
        .bus(if1)
    );
    sram_demux_1x2 #(.RD_LAT(3)) u2 (
        .clk(clk), .reset(rst),
`ifdef SRAM_DEMUX_STAT_EN
        .stat_ram_cnt(st_ram2), .stat_conf_cnt(st_conf2),
`endif
        .bus(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return a + 32'h1111_0000;
    endfunction

    function automatic logic [31:0] conf_val(input logic [31:0] a);
        return a ^ 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        return ((a & 32'hFFFF_0000) == 32'hBFAF_0000) ? conf_val(a) : ram_val(a);
    endfunction

    // Shared CPU stimulus
    assign if0.cpu_en = en;  assign if0.cpu_wen = wen;
    assign if0.cpu_addr = addr;  assign if0.cpu_wdata = wdata;
    assign if1.cpu_en = en;  assign if1.cpu_wen = wen;
    assign if1.cpu_addr = addr;  assign if1.cpu_wdata = wdata;
    assign if2.cpu_en = en;  assign if2.cpu_wen = wen;
    assign if2.cpu_addr = addr;  assign if2.cpu_wdata = wdata;

    // Slave models: remember each read request, answer it RD_LAT cycles later.
    logic        sr_v [3][4];
    logic        sc_v [3][4];
    logic [31:0] sa   [3][4];

    always @(posedge clk) begin
        sr_v[0][0] <= if0.ram_en  && (if0.ram_wen  == 4'h0);
        sc_v[0][0] <= if0.conf_en && (if0.conf_wen == 4'h0);
        sa[0][0]   <= if0.ram_addr;
        sr_v[1][0] <= if1.ram_en  && (if1.ram_wen  == 4'h0);
        sc_v[1][0] <= if1.conf_en && (if1.conf_wen == 4'h0);
        sa[1][0]   <= if1.ram_addr;
        sr_v[2][0] <= if2.ram_en  && (if2.ram_wen  == 4'h0);
        sc_v[2][0] <= if2.conf_en && (if2.conf_wen == 4'h0);
        sa[2][0]   <= if2.ram_addr;
        for (int k = 0; k < 3; k++) begin
            for (int s = 1; s < 4; s++) begin
                sr_v[k][s] <= sr_v[k][s-1];
                sc_v[k][s] <= sc_v[k][s-1];
                sa[k][s]   <= sa[k][s-1];
            end
        end
    end

    assign if0.ram_rdata  = sr_v[0][0] ? ram_val(sa[0][0])  : 32'hDEAD_BEEF;
    assign if0.conf_rdata = sc_v[0][0] ? conf_val(sa[0][0]) : 32'hDEAD_BEEF;
    assign if1.ram_rdata  = sr_v[1][1] ? ram_val(sa[1][1])  : 32'hDEAD_BEEF;
    assign if1.conf_rdata = sc_v[1][1] ? conf_val(sa[1][1]) : 32'hDEAD_BEEF;
    assign if2.ram_rdata  = sr_v[2][2] ? ram_val(sa[2][2])  : 32'hDEAD_BEEF;
    assign if2.conf_rdata = sc_v[2][2] ? conf_val(sa[2][2]) : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %0h want %0h", nm, cyc, got, exp);
        end
    endtask

    // Scoreboard check for one instance, called once per cycle.
    task automatic sb_check(input int k, input logic rv, input logic [31:0] rd);
        exp_t e;
        logic has;
        has = 1'b0;
        e.data = 32'h0;
        e.due = 0;
        case (k)
            0: if (q0.size() > 0 && q0[0].due == cyc) begin has = 1'b1; e = q0.pop_front(); end
            1: if (q1.size() > 0 && q1[0].due == cyc) begin has = 1'b1; e = q1.pop_front(); end
            default: if (q2.size() > 0 && q2[0].due == cyc) begin has = 1'b1; e = q2.pop_front(); end
        endcase
        n_cmp++;
        if (rv !== has) begin
            n_bad++;
            $display("FAIL sb_rvalid lat%0d cyc %0d: got %0b want %0b", k + 1, cyc, rv, has);
        end else if (has && rd !== e.data) begin
            n_bad++;
            $display("FAIL sb_rdata lat%0d cyc %0d: got %h want %h", k + 1, cyc, rd, e.data);
        end
        if (rst) chk($sformatf("rst_rdata_lat%0d", k + 1), 128'(rd), 128'(32'h0));
    endtask

    always @(negedge clk) begin
        sb_check(0, if0.cpu_rvalid, if0.cpu_rdata);
        sb_check(1, if1.cpu_rvalid, if1.cpu_rdata);
        sb_check(2, if2.cpu_rvalid, if2.cpu_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e;
        wen = w;
        addr = a;
        wdata = d;
        if (e && w == 4'h0 && !rst) begin
            q0.push_back('{exp_read(a), cyc + 2});
            q1.push_back('{exp_read(a), cyc + 3});
            q2.push_back('{exp_read(a), cyc + 4});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            step();
        end
    endtask

    function automatic vec_t mk(input logic e, input logic [3:0] w, input logic [31:0] a,
                                input logic [31:0] d, input logic [9:0] c);
        vec_t v;
        v.en = e; v.wen = w; v.addr = a; v.wdata = d; v.exp_ctl = c;
        return v;
    endfunction

    vec_t        tbl[15];
    logic [7:0]  pat0;
    logic [7:0]  pat2;
    int          nrv;
    int          sel;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1;
        en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;

        //                en    wen    addr            wdata          {ram_en,ram_wen,conf_en,conf_wen}
        tbl[0]  = mk(1'b1, 4'h0, 32'h0000_1000, 32'h0,         {1'b1, 4'h0, 1'b0, 4'h0});
        tbl[1]  = mk(1'b1, 4'hF, 32'hBFAF_F000, 32'hA5A5_A5A5, {1'b0, 4'h0, 1'b1, 4'hF});
        tbl[2]  = mk(1'b1, 4'h0, 32'hBFAE_FFFC, 32'h0,         {1'b1, 4'h0, 1'b0, 4'h0});
        tbl[3]  = mk(1'b1, 4'h0, 32'hBFAF_0000, 32'h0,         {1'b0, 4'h0, 1'b1, 4'h0});
        tbl[4]  = mk(1'b1, 4'h0, 32'hBFAF_FFFC, 32'h0,         {1'b0, 4'h0, 1'b1, 4'h0});
        tbl[5]  = mk(1'b1, 4'h0, 32'hBFB0_0000, 32'h0,         {1'b1, 4'h0, 1'b0, 4'h0});
        tbl[6]  = mk(1'b1, 4'h0, 32'hBFAF_FFFF, 32'h0,         {1'b0, 4'h0, 1'b1, 4'h0});
        tbl[7]  = mk(1'b1, 4'h0, 32'hBFAE_FFFF, 32'h0,         {1'b1, 4'h0, 1'b0, 4'h0});
        tbl[8]  = mk(1'b0, 4'hF, 32'h0000_0100, 32'h1111_2222, {1'b0, 4'hF, 1'b0, 4'h0});
        tbl[9]  = mk(1'b0, 4'hF, 32'hBFAF_0010, 32'h3333_4444, {1'b0, 4'h0, 1'b0, 4'hF});
        tbl[10] = mk(1'b1, 4'h3, 32'h0000_2000, 32'h5555_6666, {1'b1, 4'h3, 1'b0, 4'h0});
        tbl[11] = mk(1'b1, 4'h0, 32'hBFAF_1234, 32'h0,         {1'b0, 4'h0, 1'b1, 4'h0});
        tbl[12] = mk(1'b1, 4'hC, 32'hBFAF_0004, 32'h7777_8888, {1'b0, 4'h0, 1'b1, 4'hC});
        tbl[13] = mk(1'b1, 4'h0, 32'h0000_0044, 32'h0,         {1'b1, 4'h0, 1'b0, 4'h0});
        tbl[14] = mk(1'b0, 4'h0, 32'h0000_0000, 32'h0,         {1'b0, 4'h0, 1'b0, 4'h0});

        // Reset state: enables blocked and return registers cleared.
        drive(1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rst_ctl", 128'({if0.ram_en, if0.ram_wen, if0.conf_en, if0.conf_wen}), 128'(10'h0));
        chk("rst_rvalid", 128'(if0.cpu_rvalid), 128'(1'b0));
        chk("rst_rdata", 128'(if0.cpu_rdata), 128'(32'h0));
        step();
        rst = 1'b0;
        idle(2);

`ifdef SRAM_DEMUX_STAT_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF, 32'h0000_0200 + 32'(i * 4), 32'h0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'hF, 32'hBFAF_0200, 32'h0);
            step();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("stat_ram_3", 128'(st_ram0), 128'(16'd3));
        chk("stat_conf_2", 128'(st_conf0), 128'(16'd2));
        step();
        for (int i = 0; i < 65531; i++) begin
            drive(1'b1, 4'hF, 32'h0000_0300, 32'h0);
            step();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("stat_ram_fffe", 128'(st_ram0), 128'(16'hFFFE));
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF, 32'h0000_0300, 32'h0);
            step();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("stat_ram_sat", 128'(st_ram0), 128'(16'hFFFF));
        chk("stat_conf_hold", 128'(st_conf0), 128'(16'd2));
        step();
`endif

        // Table of request-path vectors, applied back to back.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i),
                128'({if0.ram_en, if0.ram_wen, if0.conf_en, if0.conf_wen}), 128'(tbl[i].exp_ctl));
            chk($sformatf("vec%0d_bcast", i),
                {if0.ram_addr, if0.conf_addr, if0.ram_wdata, if0.conf_wdata},
                {tbl[i].addr, tbl[i].addr, tbl[i].wdata, tbl[i].wdata});
            step();
        end
        idle(6);

        // Single RAM read on the RD_LAT=1 instance.
        drive(1'b1, 4'h0, 32'h0000_1000, 32'h0);
        @(negedge clk);
        chk("single_en", 128'({if0.ram_en, if0.conf_en}), 128'(2'b10));
        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("single_t1_rvalid", 128'(if0.cpu_rvalid), 128'(1'b0));
        step();
        @(negedge clk);
        chk("single_t2", 128'({if0.cpu_rvalid, if0.cpu_rdata}), 128'({1'b1, 32'h1111_1000}));
        step();
        idle(5);

        // Confreg write: no return pulse on any instance.
        drive(1'b1, 4'hF, 32'hBFAF_F000, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("cwr_ctl", 128'({if0.ram_en, if0.ram_wen, if0.conf_en, if0.conf_wen}),
            128'({1'b0, 4'h0, 1'b1, 4'hF}));
        step();
        nrv = 0;
        for (int j = 0; j < 5; j++) begin
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            nrv += int'(if0.cpu_rvalid) + int'(if1.cpu_rvalid) + int'(if2.cpu_rvalid);
            step();
        end
        chk("cwr_no_rvalid", 128'(nrv), 128'(0));

        // Interleaved RAM / conf / RAM reads with no gaps.
        pat0 = '0;
        pat2 = '0;
        for (int j = 0; j < 8; j++) begin
            case (j)
                0: drive(1'b1, 4'h0, 32'h0000_0040, 32'h0);
                1: drive(1'b1, 4'h0, 32'hBFAF_0040, 32'h0);
                2: drive(1'b1, 4'h0, 32'h0000_0080, 32'h0);
                default: drive(1'b0, 4'h0, 32'h0, 32'h0);
            endcase
            @(negedge clk);
            pat0[j] = if0.cpu_rvalid;
            pat2[j] = if2.cpu_rvalid;
            if (j == 6) chk("ilv_last_rdata", 128'(if2.cpu_rdata), 128'(32'h1111_0080));
            step();
        end
        chk("ilv_pat_lat1", 128'(pat0), 128'(8'b0001_1100));
        chk("ilv_pat_lat3", 128'(pat2), 128'(8'b0111_0000));
        idle(3);

        // Reset pulsed while a read is in flight.
        drive(1'b1, 4'h0, 32'h0000_3000, 32'h0);
        step();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        drive(1'b1, 4'hF, 32'hBFAF_0000, 32'h1234_5678);
        @(negedge clk);
        chk("midrst_ctl", 128'({if1.ram_en, if1.ram_wen, if1.conf_en, if1.conf_wen}), 128'(10'h0));
        step();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("midrst_t%0d", j + 2), 128'({if1.cpu_rvalid, if1.cpu_rdata}), 128'(33'h0));
            step();
        end
        drive(1'b1, 4'h0, 32'h0000_3400, 32'h0);
        step();
        idle(6);
        @(negedge clk);
        chk("post_rst_hold", 128'(if1.cpu_rdata), 128'(32'h1111_3400));
        step();

        // Random traffic across both windows and the window edges.
        for (int j = 0; j < 300; j++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: addr = {16'hBFAF, 16'($urandom)};
                1: addr = {16'h0000, 16'($urandom)};
                2: addr = {28'hBFAE_FFF, 4'($urandom)};
                default: addr = {16'hBFB0, 16'($urandom)};
            endcase
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                  addr, $urandom);
            step();
        end
        idle(6);

        chk("queues_drained", 128'(q0.size() + q1.size() + q2.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
